// File: rtl/if_id_pkg.sv
// Shared types for the IF/ID fetch queue: the queued entry layout and the bubble encoding.
package if_id_pkg;

  localparam int IFQ_XLEN = 32;
  localparam int IFQ_ILEN = 32;

  localparam logic [IFQ_ILEN-1:0] NOP_INSTR = 32'h0;

  typedef struct packed {
    logic [IFQ_XLEN-1:0] pc;
    logic [IFQ_ILEN-1:0] instr;
    logic                btb_taken;
    logic                bht_taken;
    logic [IFQ_XLEN-1:0] pred_target;
  } fetch_entry_t;

endpackage

// File: rtl/if_id_fetch_queue_storage.sv
// Entry array for the fetch queue: one synchronous write port and one combinational read port.
module ifq_storage
  import if_id_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  fetch_entry_t             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output fetch_entry_t             rdata
);

  fetch_entry_t mem [DEPTH];

  // Contents carry no reset; validity is tracked entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_fetch_queue.sv
// DEPTH-entry IF/ID fetch queue: tracks one in-flight 1-cycle imem read, queues it with its
// prediction metadata and presents the head to ID as a zero bubble when nothing is valid.
module if_id_fetch_queue
  import if_id_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = IFQ_XLEN,
  parameter int ILEN  = IFQ_ILEN
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [XLEN-1:0]            req_pc,
  input  logic                       req_btb_taken,
  input  logic                       req_bht_taken,
  input  logic [XLEN-1:0]            req_pred_target,
  input  logic [ILEN-1:0]            imem_rdata,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [XLEN-1:0]            id_pc,
  output logic [ILEN-1:0]            id_instr,
  output logic                       id_btb_taken,
  output logic                       id_bht_taken,
  output logic [XLEN-1:0]            id_pred_target,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW:0]     occ;
  logic            acc;
  logic            wr_en;
  logic            deq;

  logic            pend_vld_p1;
  logic [XLEN-1:0] pend_pc_p1;
  logic            pend_btb_p1;
  logic            pend_bht_p1;
  logic [XLEN-1:0] pend_tgt_p1;

  fetch_entry_t    wr_entry;
  fetch_entry_t    head;

  // The in-flight read counts as occupied so its write always has a slot.
  assign occ       = {1'b0, count} + {{CW{1'b0}}, pend_vld_p1};
  assign req_ready = ~flush & (occ < (CW+1)'(DEPTH));
  assign acc       = req_valid & req_ready;
  assign wr_en     = pend_vld_p1 & ~flush;
  assign id_valid  = (count != '0) & ~flush;
  assign deq       = id_valid & id_ready;

  // ---- stage p0 -> p1: capture request metadata while imem performs the read ----
  always_ff @(posedge clk) begin
    if (acc) begin
      pend_pc_p1  <= req_pc;
      pend_btb_p1 <= req_btb_taken;
      pend_bht_p1 <= req_bht_taken;
      pend_tgt_p1 <= req_pred_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld_p1 <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else if (flush) begin
      pend_vld_p1 <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      pend_vld_p1 <= acc;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (deq)   rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr_en) - CW'(deq);
    end
  end

  // ---- stage p1 -> queue: join metadata with the returning instruction word ----
  always_comb begin
    wr_entry             = '0;
    wr_entry.pc          = pend_pc_p1;
    wr_entry.instr       = imem_rdata;
    wr_entry.btb_taken   = pend_btb_p1;
    wr_entry.bht_taken   = pend_bht_p1;
    wr_entry.pred_target = pend_tgt_p1;
  end

  ifq_storage #(.DEPTH(DEPTH)) u_storage (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_comb begin
    id_pc          = '0;
    id_instr       = NOP_INSTR;
    id_btb_taken   = 1'b0;
    id_bht_taken   = 1'b0;
    id_pred_target = '0;
    if (id_valid) begin
      id_pc          = head.pc;
      id_instr       = head.instr;
      id_btb_taken   = head.btb_taken;
      id_bht_taken   = head.bht_taken;
      id_pred_target = head.pred_target;
    end
  end

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Bench for if_id_fetch_queue: fixed vector table, directed corner sequences and random traffic
// checked against a queue-based reference model.
module tb_if_id_fetch_queue;
  import if_id_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk, rst_n, flush, req_valid, req_ready, req_btb_taken, req_bht_taken;
  logic [31:0]   req_pc, req_pred_target, imem_rdata;
  logic          id_valid, id_ready, id_btb_taken, id_bht_taken;
  logic [31:0]   id_pc, id_instr, id_pred_target;
  logic [CW-1:0] count;

  if_id_fetch_queue #(.DEPTH(DEPTH), .XLEN(32), .ILEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
    .req_btb_taken(req_btb_taken), .req_bht_taken(req_bht_taken),
    .req_pred_target(req_pred_target), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr),
    .id_btb_taken(id_btb_taken), .id_bht_taken(id_bht_taken),
    .id_pred_target(id_pred_target), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: ordered list of queued entries plus one outstanding read.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        btb;
    logic        bht;
    logic [31:0] tgt;
  } ment_t;

  ment_t       m_q[$];
  logic        m_pend;
  ment_t       m_pend_e;
  logic        last_acc, last_deq;
  logic [31:0] last_deq_pc;
  logic [31:0] prev_req_pc;
  int          max_cnt;

  // Instruction RAM contents as seen by the bench: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00000013;
  endfunction

  // One cycle: drive at posedge+1, check at negedge, advance model, return at next posedge+1.
  task automatic step(input logic fl, input logic rv, input logic [31:0] pc, input logic bt,
                      input logic bh, input logic [31:0] tg, input logic idr);
    logic  e_ready, e_valid;
    ment_t h;
    flush = fl; req_valid = rv; req_pc = pc; req_btb_taken = bt; req_bht_taken = bh;
    req_pred_target = tg; id_ready = idr; imem_rdata = mem_word(prev_req_pc);
    @(negedge clk);
    e_ready = !fl && ((m_q.size() + int'(m_pend)) < DEPTH);
    e_valid = !fl && (m_q.size() != 0);
    h = e_valid ? m_q[0] : '0;
    chk("req_ready", {31'b0, req_ready}, {31'b0, e_ready});
    chk("id_valid", {31'b0, id_valid}, {31'b0, e_valid});
    chk("count", 32'(count), 32'(m_q.size()));
    chk("id_pc", id_pc, h.pc);
    chk("id_instr", id_instr, h.instr);
    chk("id_btb", {31'b0, id_btb_taken}, {31'b0, h.btb});
    chk("id_bht", {31'b0, id_bht_taken}, {31'b0, h.bht});
    chk("id_tgt", id_pred_target, h.tgt);
    if (int'(count) > max_cnt) max_cnt = int'(count);
    last_acc    = rv && e_ready;
    last_deq    = e_valid && idr;
    last_deq_pc = h.pc;
    if (fl) begin
      m_q.delete();
      m_pend = 1'b0;
    end else begin
      if (last_deq) void'(m_q.pop_front());
      if (m_pend) begin
        m_pend_e.instr = imem_rdata;
        m_q.push_back(m_pend_e);
      end
      m_pend = last_acc;
      if (last_acc) m_pend_e = '{pc: pc, instr: 32'h0, btb: bt, bht: bh, tgt: tg};
    end
    prev_req_pc = pc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; id_ready = 1'b0;
    m_q.delete(); m_pend = 1'b0; prev_req_pc = 32'h0;
    #1;
    chk("rst_id_valid", {31'b0, id_valid}, 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
    chk("rst_id_instr", id_instr, 32'h0);
    chk("rst_id_pc", id_pc, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic fl; logic rv; logic [31:0] pc; logic bt; logic bh; logic [31:0] tg;
    logic [31:0] imem; logic idr;
    logic e_rdy; logic e_vld; logic [31:0] e_pc; logic [31:0] e_ins;
    logic e_bt; logic e_bh; logic [31:0] e_tg; int e_cnt;
  } vec_t;

  vec_t vt[11];

  initial begin
    int          idx, ndeq, first_c, last_c;
    logic [31:0] pcs[$];
    logic [3:0]  pat;

    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_pc = '0; req_btb_taken = 1'b0;
    req_bht_taken = 1'b0; req_pred_target = '0; imem_rdata = '0; id_ready = 1'b0;
    m_pend = 1'b0; m_pend_e = '0; prev_req_pc = '0; max_cnt = 0;
    last_acc = 1'b0; last_deq = 1'b0; last_deq_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    //        fl  rv  pc       bt  bh  tg       imem          idr | rdy vld e_pc   e_ins   ebt ebh e_tg  cnt
    vt[0]  = '{0, 1, 32'h100, 1, 0, 32'h140, 32'h0,        0,  1, 0, 32'h0,   32'h0,        0, 0, 32'h0,   0};
    vt[1]  = '{0, 0, 32'h0,   0, 0, 32'h0,   32'h00500093, 0,  1, 0, 32'h0,   32'h0,        0, 0, 32'h0,   0};
    vt[2]  = '{0, 0, 32'h0,   0, 0, 32'h0,   32'h0,        1,  1, 1, 32'h100, 32'h00500093, 1, 0, 32'h140, 1};
    vt[3]  = '{0, 0, 32'h0,   0, 0, 32'h0,   32'h0,        1,  1, 0, 32'h0,   32'h0,        0, 0, 32'h0,   0};
    vt[4]  = '{0, 1, 32'h200, 0, 0, 32'h240, 32'h0,        0,  1, 0, 32'h0,   32'h0,        0, 0, 32'h0,   0};
    vt[5]  = '{1, 1, 32'h280, 1, 1, 32'h2C0, 32'hDEADBEEF, 0,  0, 0, 32'h0,   32'h0,        0, 0, 32'h0,   0};
    vt[6]  = '{0, 1, 32'h300, 0, 1, 32'h340, 32'h11111111, 0,  1, 0, 32'h0,   32'h0,        0, 0, 32'h0,   0};
    vt[7]  = '{0, 0, 32'h0,   0, 0, 32'h0,   32'h00A00113, 0,  1, 0, 32'h0,   32'h0,        0, 0, 32'h0,   0};
    vt[8]  = '{0, 0, 32'h0,   0, 0, 32'h0,   32'h0,        0,  1, 1, 32'h300, 32'h00A00113, 0, 1, 32'h340, 1};
    vt[9]  = '{1, 0, 32'h0,   0, 0, 32'h0,   32'h0,        1,  0, 0, 32'h0,   32'h0,        0, 0, 32'h0,   1};
    vt[10] = '{0, 0, 32'h0,   0, 0, 32'h0,   32'h0,        1,  1, 0, 32'h0,   32'h0,        0, 0, 32'h0,   0};

    for (int i = 0; i < 11; i++) begin
      flush = vt[i].fl; req_valid = vt[i].rv; req_pc = vt[i].pc; req_btb_taken = vt[i].bt;
      req_bht_taken = vt[i].bh; req_pred_target = vt[i].tg; imem_rdata = vt[i].imem;
      id_ready = vt[i].idr;
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), {31'b0, req_ready}, {31'b0, vt[i].e_rdy});
      chk($sformatf("vec%0d_valid", i), {31'b0, id_valid}, {31'b0, vt[i].e_vld});
      chk($sformatf("vec%0d_pc", i), id_pc, vt[i].e_pc);
      chk($sformatf("vec%0d_instr", i), id_instr, vt[i].e_ins);
      chk($sformatf("vec%0d_btb", i), {31'b0, id_btb_taken}, {31'b0, vt[i].e_bt});
      chk($sformatf("vec%0d_bht", i), {31'b0, id_bht_taken}, {31'b0, vt[i].e_bh});
      chk($sformatf("vec%0d_tgt", i), id_pred_target, vt[i].e_tg);
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].e_cnt));
      @(posedge clk);
      #1;
    end

    // Reset mid-stream: three queued, a fourth in flight, then a one-cycle reset pulse.
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 1, 32'h500 + 32'(4*i), 0, 0, 32'h0, 0);
    chk("midrst_count_before", 32'(count), 32'h3);
    do_reset();
    step(0, 0, 32'h0, 0, 0, 32'h0, 0);
    step(0, 0, 32'h0, 0, 0, 32'h0, 0);
    chk("midrst_stale_dropped", 32'(count), 32'h0);

    // Fill with ID stalled: exactly DEPTH accepted, then drained in order.
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      step(0, 1, 32'(4*idx), 0, 0, 32'h0, 0);
      if (last_acc) idx++;
    end
    chk("fill_accepted", 32'(idx), 32'(DEPTH));
    chk("fill_count", 32'(count), 32'(DEPTH));
    ndeq = 0;
    for (int c = 0; c < 6; c++) begin
      step(0, 0, 32'h0, 0, 0, 32'h0, 1);
      if (last_deq) begin
        chk("fill_drain_order", last_deq_pc, 32'(4*ndeq));
        ndeq++;
      end
    end
    chk("fill_drain_n", 32'(ndeq), 32'(DEPTH));

    // Back-to-back streaming across pointer wrap.
    idx = 0; ndeq = 0; first_c = -1; last_c = -1; max_cnt = 0;
    for (int c = 0; c < 14; c++) begin
      step(0, idx < 10, 32'(4*idx), idx[0], idx[1], 32'(4*idx + 64), 1);
      if (last_acc) idx++;
      if (last_deq) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        chk("stream_order", last_deq_pc, 32'(4*ndeq));
        ndeq++;
      end
    end
    chk("stream_n", 32'(ndeq), 32'd10);
    chk("stream_first", 32'(first_c), 32'd2);
    chk("stream_last", 32'(last_c), 32'd11);
    chk("stream_maxcnt_le2", {31'b0, max_cnt > 2}, 32'h0);

    // Stall/resume with id_ready cycling 1,0,0,1.
    pat = 4'b1001; idx = 0; ndeq = 0; max_cnt = 0;
    for (int c = 0; c < 44; c++) begin
      step(0, idx < 12, 32'h400 + 32'(4*idx), 1, 0, 32'h800 + 32'(idx), pat[c % 4]);
      if (last_acc) idx++;
      if (last_deq) begin
        chk("stall_order", last_deq_pc, 32'h400 + 32'(4*ndeq));
        ndeq++;
      end
    end
    chk("stall_n", 32'(ndeq), 32'd12);
    chk("stall_maxcnt_le_depth", {31'b0, max_cnt > DEPTH}, 32'h0);

    // Random traffic with occasional flushes against the reference model.
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7, $urandom, 1'($urandom),
           1'($urandom), $urandom, $urandom_range(0, 9) < 6);
      pcs.push_back(req_pc);
    end
    chk("random_ran", 32'(pcs.size()), 32'd400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
